simon_sequencer: RTL and testbench

- Round controller for the Simon game.
- Stores the colour pattern in a register file built from D flip-flops and extends it by one random colour per round.
- Plays the pattern on the lamps, then checks player presses against it.
- Sits between the debounced button front-end and the lamp drivers; reports win/lose to the top level.

---
 rtl/simon_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   Round controller for the Simon game. Keeps the colour pattern in a
//   flip-flop register file, appends one pseudo-random colour per round,
//   plays the pattern on the lamps, then checks the player's presses.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset, clears all state
//   start      in   one-cycle pulse, begins a new game (ignored while busy)
//   btn_valid  in   one-cycle pulse, player pressed a button
//   btn_color  in   [1:0] colour of the press, sampled with btn_valid
//   lamp       out  [3:0] one-hot lamp drive, 0 = dark
//   busy       out  high while a game is in progress
//   round      out  current pattern length, held in WIN/LOSE
//   win        out  high while in WIN
//   lose       out  high while in LOSE
//
// Optional feature (macro SIMON_ECHO_EN)
//   When defined, each correct press in INPUT lights its colour for
//   SHOW_TICKS cycles. When undefined, the lamps stay dark during INPUT.
// -----------------------------------------------------------------------------
module simon_sequencer #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 64,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             btn_valid,
  input  logic [1:0]                       btn_color,
  output logic [3:0]                       lamp,
  output logic                             busy,
  output logic [$clog2(MAX_LEN + 1) - 1:0] round,
  output logic                             win,
  output logic                             lose
);

  localparam int unsigned RW   = $clog2(MAX_LEN + 1);
  localparam int unsigned TMAX = (TIMEOUT_TICKS > SHOW_TICKS)
                                 ? ((TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS)
                                 : ((SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_SHOW,
    S_GAP,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [RW-1:0]   len_q, len_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      pattern [MAX_LEN];
  logic            wr_en;
  logic            hit;
  logic [1:0]      cur_col;
  logic [1:0]      show_col;
  logic [3:0]      lamp_d;
  logic            busy_d, win_d, lose_d;
  logic [RW-1:0]   round_d;

`ifdef SIMON_ECHO_EN
  localparam int unsigned EW = $clog2(SHOW_TICKS + 1);
  logic [EW-1:0]   echo_cnt_q, echo_cnt_d;
  logic [1:0]      echo_col_q, echo_col_d;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    tick_d   = tick_q;
    wr_en    = 1'b0;
    hit      = 1'b0;
    cur_col  = 2'b00;
    show_col = 2'b00;
    lamp_d   = 4'b0000;

    // x^8+x^6+x^5+x^4+1, shifting left; free-running so start time seeds it
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (RW'(i) == idx_q) cur_col = pattern[i];
    end

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          len_d   = '0;
          state_d = S_EXTEND;
        end
      end
      S_EXTEND: begin
        wr_en   = 1'b1;
        len_d   = len_q + RW'(1);
        idx_d   = '0;
        tick_d  = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (tick_q == TW'(SHOW_TICKS - 1)) begin
          tick_d  = '0;
          state_d = S_GAP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_GAP: begin
        if (tick_q == TW'(GAP_TICKS - 1)) begin
          tick_d = '0;
          if (idx_q + RW'(1) == len_q) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + RW'(1);
            state_d = S_SHOW;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_INPUT: begin
        if (btn_valid) begin
          if (btn_color == cur_col) begin
            hit = 1'b1;
            if (idx_q == len_q - RW'(1)) begin
              state_d = (len_q == RW'(MAX_LEN)) ? S_WIN : S_EXTEND;
            end else begin
              idx_d  = idx_q + RW'(1);
              tick_d = '0;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (tick_q == TW'(TIMEOUT_TICKS - 1)) begin
          state_d = S_LOSE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Colour for the next SHOW cycle; bypass the entry being written this cycle
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (RW'(i) == idx_d) show_col = pattern[i];
    end
    if (wr_en && (idx_d == len_q)) show_col = lfsr_q[1:0];

    if (state_d == S_SHOW) lamp_d = 4'b0001 << show_col;

`ifdef SIMON_ECHO_EN
    // Echo restarts on every correct press and is cut when INPUT is left
    echo_col_d = echo_col_q;
    echo_cnt_d = (echo_cnt_q != '0) ? echo_cnt_q - EW'(1) : '0;
    if (hit) begin
      echo_cnt_d = EW'(SHOW_TICKS);
      echo_col_d = btn_color;
    end
    if (state_d != S_INPUT) echo_cnt_d = '0;
    if ((state_d == S_INPUT) && (echo_cnt_d != '0)) lamp_d = 4'b0001 << echo_col_d;
`endif

    busy_d  = (state_d == S_EXTEND) || (state_d == S_SHOW) ||
              (state_d == S_GAP)    || (state_d == S_INPUT);
    win_d   = (state_d == S_WIN);
    lose_d  = (state_d == S_LOSE);
    // Length already reads as the extended value during the EXTEND cycle
    round_d = (state_d == S_EXTEND) ? len_d + RW'(1) : len_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      len_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      lamp    <= 4'b0000;
      busy    <= 1'b0;
      round   <= '0;
      win     <= 1'b0;
      lose    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      lamp    <= lamp_d;
      busy    <= busy_d;
      round   <= round_d;
      win     <= win_d;
      lose    <= lose_d;
    end
  end

  // Pattern register file; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (RW'(i) == len_q) pattern[i] <= lfsr_q[1:0];
      end
    end
  end

`ifdef SIMON_ECHO_EN
  // Echo lamp state
  always_ff @(posedge clock) begin
    if (reset) begin
      echo_cnt_q <= '0;
      echo_col_q <= 2'b00;
    end else begin
      echo_cnt_q <= echo_cnt_d;
      echo_col_q <= echo_col_d;
    end
  end
`endif

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
//   Scoreboard bench for simon_sequencer (MAX_LEN=2, other parameters default).
//   Stimulus pushes per-cycle expected outputs into a queue; a monitor on the
//   falling edge pops the entry for the current cycle and compares.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;

  localparam int unsigned MAXL = 2;
  localparam int unsigned RW   = $clog2(MAXL + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          btn_valid;
  logic [1:0]    btn_color;
  logic [3:0]    lamp;
  logic          busy;
  logic [RW-1:0] round;
  logic          win;
  logic          lose;

  simon_sequencer #(
    .MAX_LEN      (MAXL),
    .SHOW_TICKS   (4),
    .GAP_TICKS    (2),
    .TIMEOUT_TICKS(64),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .btn_valid(btn_valid),
    .btn_color(btn_color),
    .lamp     (lamp),
    .busy     (busy),
    .round    (round),
    .win      (win),
    .lose     (lose)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [3:0]    lamp;
    logic          busy;
    logic [RW-1:0] round;
    logic          win;
    logic          lose;
    string         tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] m     = 8'hA5;
  logic [1:0] pat [MAXL];
  logic [1:0] p0_first;
  int         e_cyc;

  // Reference LFSR: feedback is parity of taps 8,6,5,4
  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] v;
    v = 4'b0000;
    v[c] = 1'b1;
    return v;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) m <= 8'hA5;
    else       m <= nxt(m);
  end

  // Monitor: compare DUT outputs against the entry scheduled for this cycle
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.tag, e.cyc, cyc);
    end
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      total++;
      if ({lamp, busy, round, win, lose} !== {e.lamp, e.busy, e.round, e.win, e.lose}) begin
        bad++;
        $display("FAIL %s cyc=%0d got lamp=%b busy=%b round=%0d win=%b lose=%b want lamp=%b busy=%b round=%0d win=%b lose=%b",
                 e.tag, cyc, lamp, busy, round, win, lose, e.lamp, e.busy, e.round, e.win, e.lose);
      end
    end
  end

  task automatic expect_at(input int c, input logic [3:0] l, input logic b, input int r,
                           input logic w, input logic lo, input string tag);
    exp_t e;
    e.cyc = c; e.lamp = l; e.busy = b; e.round = RW'(r); e.win = w; e.lose = lo; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expect_at(cyc + 1, 4'b0000, 1'b0, 0, 1'b0, 1'b0, "reset");
    expect_at(cyc + 2, 4'b0000, 1'b0, 0, 1'b0, 1'b0, "reset_hold");
    step();
    step();
    reset = 1'b0;
  endtask

  // Pulse start; the colour appended in EXTEND is the LFSR value of the next cycle
  task automatic start_game();
    logic [7:0] t;
    t      = nxt(m);
    pat[0] = t[1:0];
    start  = 1'b1;
    expect_at(cyc + 1, 4'b0000, 1'b1, 1, 1'b0, 1'b0, "extend");
    e_cyc  = cyc + 1;
    step();
    start  = 1'b0;
  endtask

  // Playback trace following an EXTEND at cycle e, then first INPUT cycle
  task automatic push_playback(input int e, input int r);
    for (int j = 0; j < r; j++) begin
      for (int t = 0; t < 4; t++) expect_at(e + 1 + 6*j + t, oh(pat[j]), 1'b1, r, 1'b0, 1'b0, "show");
      for (int t = 0; t < 2; t++) expect_at(e + 5 + 6*j + t, 4'b0000, 1'b1, r, 1'b0, 1'b0, "gap");
    end
    expect_at(e + 1 + 6*r, 4'b0000, 1'b1, r, 1'b0, 1'b0, "input_entry");
  endtask

  task automatic play(input int r);
    push_playback(e_cyc, r);
    wait_until(e_cyc + 1 + 6*r);
  endtask

  // kind: 0 correct mid-pattern, 1 correct last -> extend, 2 correct last -> win, 3 wrong
  task automatic press(input logic [1:0] col, input int r, input int kind);
    logic [7:0] t;
    btn_valid = 1'b1;
    btn_color = col;
    case (kind)
      0: expect_at(cyc + 1, 4'b0000, 1'b1, r, 1'b0, 1'b0, "press_ok");
      1: begin
        t      = nxt(m);
        pat[r] = t[1:0];
        expect_at(cyc + 1, 4'b0000, 1'b1, r + 1, 1'b0, 1'b0, "press_extend");
        e_cyc  = cyc + 1;
      end
      2: expect_at(cyc + 1, 4'b0000, 1'b0, r, 1'b1, 1'b0, "press_win");
      default: expect_at(cyc + 1, 4'b0000, 1'b0, r, 1'b0, 1'b1, "press_wrong");
    endcase
    step();
    btn_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int         i;
    logic [1:0] w;
    reset = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_color = 2'b00;
    step();

    // Reset, idle, round 1 playback, then full win at MAX_LEN=2
    do_reset();
    step(); step(); step();
    start_game();
    p0_first = pat[0];
    play(1);
    press(pat[0], 1, 1);
    play(2);
    press(pat[0], 2, 0);
    press(pat[1], 2, 2);

    // WIN holds and ignores presses
    btn_valid = 1'b1;
    btn_color = pat[0];
    for (int k = 0; k < 4; k++) expect_at(cyc + 1 + k, 4'b0000, 1'b0, 2, 1'b1, 1'b0, "win_hold");
    step();
    btn_valid = 1'b0;
    step(); step(); step();

    // Wrong colour in round 1
    start_game();
    play(1);
    w = pat[0] + 2'd1;
    press(w, 1, 3);
    for (int k = 0; k < 3; k++) expect_at(cyc + 1 + k, 4'b0000, 1'b0, 1, 1'b0, 1'b1, "lose_hold");
    step(); step(); step();

    // Timeout with no presses in round 1
    start_game();
    play(1);
    i = cyc;
    expect_at(i + 63, 4'b0000, 1'b1, 1, 1'b0, 1'b0, "pre_timeout");
    expect_at(i + 64, 4'b0000, 1'b0, 1, 1'b0, 1'b1, "timeout");
    wait_until(i + 65);

    // Timeout in round 2 restarted by a correct press sampled 30 cycles in
    start_game();
    play(1);
    press(pat[0], 1, 1);
    play(2);
    i = cyc;
    wait_until(i + 29);
    press(pat[0], 2, 0);
    expect_at(i + 93, 4'b0000, 1'b1, 2, 1'b0, 1'b0, "pre_timeout2");
    expect_at(i + 94, 4'b0000, 1'b0, 2, 1'b0, 1'b1, "timeout2");
    wait_until(i + 95);

    // start and a wrong press during SHOW must not disturb playback
    start_game();
    push_playback(e_cyc, 1);
    wait_until(e_cyc + 2);
    start = 1'b1;
    step();
    start = 1'b0;
    btn_valid = 1'b1;
    btn_color = pat[0] + 2'd1;
    step();
    btn_valid = 1'b0;
    wait_until(e_cyc + 7);
    press(pat[0], 1, 1);

    // Reset in the middle of round 2 SHOW, then the seed sequence replays
    expect_at(e_cyc + 1, oh(pat[0]), 1'b1, 2, 1'b0, 1'b0, "show_r2");
    expect_at(e_cyc + 2, oh(pat[0]), 1'b1, 2, 1'b0, 1'b0, "show_r2b");
    wait_until(e_cyc + 2);
    do_reset();
    step(); step(); step();
    start_game();
    pat[0] = p0_first;
    play(1);
    step(); step();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
